max51_cpld: RTL and testbench

//  CPLD glue between an 8051-family MCU external bus and board peripherals.

---
 rtl/max51_pkg.sv | 27 ++
 rtl/max51_sync.sv | 32 +++
 rtl/max51_cpld.sv | 151 +++++++++++++++
 tb/tb_max51_cpld.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/max51_pkg.sv
// Shared constants and address decode for the 8051 bus glue CPLD.
`timescale 1ns / 1ps
package max51_pkg;

  localparam logic [15:0] LED_ADDR = 16'h5555;
  localparam logic [15:0] SCR_ADDR = 16'h5556;
  localparam logic [15:0] ID_ADDR  = 16'h5557;
  localparam logic [7:0]  ID_VALUE = 8'h51;

  localparam int unsigned WR_DLY   = 6;
  localparam int unsigned WR_CNT_W = $clog2(WR_DLY + 1);

  localparam logic ALE_RST    = 1'b0;
  localparam logic STROBE_RST = 1'b1;

  typedef enum logic [1:0] {RegNone, RegLed, RegScr, RegId} reg_sel_e;

  function automatic reg_sel_e decode(input logic [15:0] addr);
    case (addr)
      LED_ADDR: decode = RegLed;
      SCR_ADDR: decode = RegScr;
      ID_ADDR:  decode = RegId;
      default:  decode = RegNone;
    endcase
  endfunction

endpackage

// File: rtl/max51_sync.sv
// Two-flop synchroniser for one asynchronous MCU strobe, with edge pulses
// derived from the synchronised value.
`timescale 1ns / 1ps
module max51_sync #(
  parameter logic RstVal = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [1:0] meta_q;
  logic       prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= {2{RstVal}};
      prev_q <= RstVal;
    end else begin
      meta_q <= {meta_q[0], async_in};
      prev_q <= meta_q[1];
    end
  end

  assign sync_out = meta_q[1];
  assign rise     = meta_q[1] & ~prev_q;
  assign fall     = ~meta_q[1] & prev_q;

endmodule

// File: rtl/max51_cpld.sv
// 8051 external-bus glue: address latch, delayed MOVX write commit, LED/scratch/ID registers.
// Define MAX51_READ_EN to add the MOVX read path and the P0 tristate driver.
`timescale 1ns / 1ps
module max51_cpld
  import max51_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       mcu_wr_n,
  input  logic       mcu_rd_n,
  input  logic       mcu_ale,
  input  logic       mcu_psen_n,
  inout  wire  [7:0] mcu_p0,
  input  logic [7:0] mcu_p2,
  output logic [7:0] leds_o
);

  logic ale_s, ale_rise, ale_fall;
  logic wr_n_s, wr_rise, wr_fall;

  max51_sync #(.RstVal(ALE_RST)) u_sync_ale (
    .clk      (clk),
    .rst      (rst),
    .async_in (mcu_ale),
    .sync_out (ale_s),
    .rise     (ale_rise),
    .fall     (ale_fall)
  );

  max51_sync #(.RstVal(STROBE_RST)) u_sync_wr (
    .clk      (clk),
    .rst      (rst),
    .async_in (mcu_wr_n),
    .sync_out (wr_n_s),
    .rise     (wr_rise),
    .fall     (wr_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{ale_s, ale_rise, wr_rise, wr_fall};

  logic [15:0]         addr_q;
  logic [1:0]          settle_q, settle_d;
  logic                wr_arm_q, wr_arm_d;
  logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [7:0]          led_q, led_d, scr_q, scr_d;
  logic                commit;
  reg_sel_e            sel;

  assign sel = decode(addr_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q   <= 16'h0000;
      settle_q <= 2'd0;
      wr_arm_q <= 1'b0;
      wr_cnt_q <= '0;
      led_q    <= 8'h00;
      scr_q    <= 8'h00;
    end else begin
      if (ale_fall) addr_q <= {mcu_p2, mcu_p0};
      settle_q <= settle_d;
      wr_arm_q <= wr_arm_d;
      wr_cnt_q <= wr_cnt_d;
      led_q    <= led_d;
      scr_q    <= scr_d;
    end
  end

  // Writes stay disarmed after reset until wr_n is seen high once the synchroniser
  // holds real pin data, so a strobe already low across reset cannot commit.
  always_comb begin
    settle_d = settle_q;
    if (settle_q != 2'd2) settle_d = settle_q + 2'd1;
    wr_arm_d = wr_arm_q | ((settle_q == 2'd2) & wr_n_s);

    wr_cnt_d = wr_cnt_q;
    commit   = 1'b0;
    if (!wr_arm_q || wr_n_s) begin
      wr_cnt_d = '0;
    end else if (wr_cnt_q != WR_CNT_W'(WR_DLY)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
      commit   = (wr_cnt_q == WR_CNT_W'(WR_DLY - 1));
    end

    led_d = led_q;
    scr_d = scr_q;
    if (commit) begin
      case (sel)
        RegLed:  led_d = mcu_p0;
        RegScr:  scr_d = mcu_p0;
        default: ;
      endcase
    end
  end

  assign leds_o = led_q;

`ifdef MAX51_READ_EN
  logic rd_n_s, rd_rise, rd_fall;
  logic psen_n_s, psen_rise, psen_fall;
  logic oe_q, oe_d;
  logic [7:0] rd_data;

  max51_sync #(.RstVal(STROBE_RST)) u_sync_rd (
    .clk      (clk),
    .rst      (rst),
    .async_in (mcu_rd_n),
    .sync_out (rd_n_s),
    .rise     (rd_rise),
    .fall     (rd_fall)
  );

  max51_sync #(.RstVal(STROBE_RST)) u_sync_psen (
    .clk      (clk),
    .rst      (rst),
    .async_in (mcu_psen_n),
    .sync_out (psen_n_s),
    .rise     (psen_rise),
    .fall     (psen_fall)
  );

  logic unused_rd_edges;
  assign unused_rd_edges = ^{rd_rise, rd_fall, psen_rise, psen_fall};

  // A concurrent write strobe wins: never drive P0 while the MCU may be driving it.
  assign oe_d = ~rd_n_s & psen_n_s & wr_n_s & (sel != RegNone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) oe_q <= 1'b0;
    else     oe_q <= oe_d;
  end

  always_comb begin
    rd_data = 8'h00;
    case (sel)
      RegLed:  rd_data = led_q;
      RegScr:  rd_data = scr_q;
      RegId:   rd_data = ID_VALUE;
      default: rd_data = 8'h00;
    endcase
  end

  assign mcu_p0 = oe_q ? rd_data : 8'hzz;
`else
  logic unused_rd;
  assign unused_rd = ^{mcu_rd_n, mcu_psen_n};
  assign mcu_p0    = 8'hzz;
`endif

endmodule

// File: tb/tb_max51_cpld.sv
// Scoreboard bench for max51_cpld; P0 has pull-ups so an undriven bus reads 8'hFF.
`timescale 1ns / 1ps
module tb_max51_cpld;

  logic       clk = 1'b0;
  logic       rst, wr_n, rd_n, ale, psen_n;
  logic [7:0] p2, p0_drv, leds;
  logic       p0_en;
  wire  [7:0] mcu_p0;

  localparam logic [7:0] HIZ = 8'hFF;

  always #10 clk = ~clk;

  assign mcu_p0 = p0_en ? p0_drv : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (mcu_p0[i]);
  end

  max51_cpld dut (
    .clk        (clk),
    .rst        (rst),
    .mcu_wr_n   (wr_n),
    .mcu_rd_n   (rd_n),
    .mcu_ale    (ale),
    .mcu_psen_n (psen_n),
    .mcu_p0     (mcu_p0),
    .mcu_p2     (p2),
    .leds_o     (leds)
  );

  typedef enum {ObsLeds, ObsScr, ObsP0} obs_e;
  typedef struct {
    string      tag;
    obs_e       obs;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] led_m, scr_m;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_val(input string tag, input obs_e obs, input logic [7:0] val);
    sb.push_back(exp_t'{tag, obs, val});
  endtask

  task automatic drain();
    exp_t       e;
    logic [7:0] got;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.obs)
        ObsLeds: got = leds;
        ObsScr:  got = dut.scr_q;
        default: got = mcu_p0;
      endcase
      check_eq(e.tag, {8'h00, got}, {8'h00, e.val});
    end
  endtask

  task automatic latch_addr(input logic [15:0] a);
    p2     = a[15:8];
    p0_drv = a[7:0];
    p0_en  = 1'b1;
    ale    = 1'b1;
    #60;
    ale    = 1'b0;
    #100;
    p0_en  = 1'b0;
    #20;
  endtask

  task automatic model_wr(input logic [15:0] a, input logic [7:0] d);
    if (a == 16'h5555)      led_m = d;
    else if (a == 16'h5556) scr_m = d;
  endtask

  // low_ns is a multiple of 20 so stimulus stays on falling clock edges.
  task automatic movx_wr(input logic [15:0] a, input logic [7:0] d, input int low_ns,
                         input string tag);
    if (low_ns >= 200) model_wr(a, d);
    expect_val({tag, "_led"}, ObsLeds, led_m);
    expect_val({tag, "_scr"}, ObsScr, scr_m);
    latch_addr(a);
    p0_drv = d;
    p0_en  = 1'b1;
    wr_n   = 1'b0;
    #(low_ns - 40);
    p0_en  = 1'b0;
    #40;
    wr_n   = 1'b1;
    #100;
    drain();
  endtask

  task automatic movx_rd(input logic [15:0] a, input logic [7:0] exp, input string tag);
    expect_val(tag, ObsP0, exp);
    latch_addr(a);
    rd_n = 1'b0;
    #120;
    drain();
    expect_val({tag, "_rel"}, ObsP0, HIZ);
    rd_n = 1'b1;
    #80;
    drain();
  endtask

  initial begin
    rst    = 1'b1;
    wr_n   = 1'b1;
    rd_n   = 1'b1;
    ale    = 1'b0;
    psen_n = 1'b1;
    p2     = 8'h00;
    p0_drv = 8'h00;
    p0_en  = 1'b0;
    led_m  = 8'h00;
    scr_m  = 8'h00;

    #200;
    expect_val("rst_led", ObsLeds, 8'h00);
    expect_val("rst_scr", ObsScr, 8'h00);
    expect_val("rst_p0", ObsP0, HIZ);
    drain();
    check_eq("rst_addr", dut.addr_q, 16'h0000);
    rst = 1'b0;
    #100;

    movx_wr(16'h5555, 8'h01, 320, "wr_led");

    // Code fetch relatches the address but must not disturb the LEDs or the bus.
    expect_val("fetch_led", ObsLeds, 8'h01);
    expect_val("fetch_p0", ObsP0, HIZ);
    latch_addr(16'hFFFF);
    psen_n = 1'b0;
    #100;
    drain();
    check_eq("fetch_addr", dut.addr_q, 16'hFFFF);
    psen_n = 1'b1;
    #40;

    movx_wr(16'h1234, 8'hAA, 320, "wr_unmap");
    movx_wr(16'h5557, 8'hAA, 320, "wr_id");
    movx_wr(16'h5555, 8'hFF, 80, "wr_short");
    movx_wr(16'h5556, 8'h3C, 320, "wr_scr");
    movx_wr(16'h5555, 8'hA5, 320, "wr_led2");

`ifdef MAX51_READ_EN
    movx_rd(16'h5556, 8'h3C, "rd_scr");
    movx_rd(16'h5555, 8'hA5, "rd_led");
    movx_rd(16'h5557, 8'h51, "rd_id");
    movx_rd(16'h0000, HIZ, "rd_unmap");

    expect_val("rd_psen_p0", ObsP0, HIZ);
    latch_addr(16'h5555);
    psen_n = 1'b0;
    rd_n   = 1'b0;
    #120;
    drain();
    rd_n   = 1'b1;
    psen_n = 1'b1;
    #80;
`endif

    // Write and read strobes together: the write lands, P0 stays released.
    model_wr(16'h5556, 8'h5A);
    expect_val("wr_rd_scr", ObsScr, scr_m);
    latch_addr(16'h5556);
    p0_drv = 8'h5A;
    p0_en  = 1'b1;
    wr_n   = 1'b0;
    rd_n   = 1'b0;
    #200;
`ifdef MAX51_READ_EN
    check_eq("wr_rd_oe", {15'h0, dut.oe_q}, 16'h0000);
`endif
    p0_en = 1'b0;
    #40;
    wr_n  = 1'b1;
    rd_n  = 1'b1;
    #100;
    drain();

    movx_wr(16'h5555, 8'h5A, 320, "pre_rst");

    // Reset mid-write: registers clear at once, and the held-low strobe cannot
    // commit after reset even once the address is relatched to the LED register.
    latch_addr(16'h5555);
    p0_drv = 8'h77;
    p0_en  = 1'b1;
    wr_n   = 1'b0;
    #60;
    rst    = 1'b1;
    #1;
    led_m  = 8'h00;
    scr_m  = 8'h00;
    expect_val("rst_async_led", ObsLeds, 8'h00);
    expect_val("rst_async_scr", ObsScr, 8'h00);
    drain();
    #59;
    rst = 1'b0;
    #100;
    latch_addr(16'h5555);
    p0_drv = 8'h77;
    p0_en  = 1'b1;
    #300;
    expect_val("rst_hold_led", ObsLeds, 8'h00);
    drain();
    p0_en = 1'b0;
    #40;
    wr_n  = 1'b1;
    #100;
    expect_val("rst_rise_led", ObsLeds, 8'h00);
    drain();

    movx_wr(16'h5555, 8'hC3, 320, "post_rst");

`ifdef MAX51_READ_EN
    // Reset during a read releases P0 without waiting for a clock.
    latch_addr(16'h5555);
    rd_n = 1'b0;
    #120;
    expect_val("rd_before_rst", ObsP0, 8'hC3);
    drain();
    rst = 1'b1;
    #1;
    expect_val("rd_rst_p0", ObsP0, HIZ);
    drain();
    #59;
    rst  = 1'b0;
    rd_n = 1'b1;
    #100;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
